// File: rtl/spinner_quad_gen.sv
// spinner_quad_gen
//   Quadrature (AB) generator for the Arkanoid core's 2-bit spinner input.
//   Signed paddle deltas (mouse, stick, D-pad or USB spinner) are buffered in a
//   saturating accumulator and drained one quadrature step per rate tick.
//   An external 600-ppr encoder can be passed through instead. Only phase-A
//   edges are counted, so it behaves like the original 300-ppr spinner.
//
// Ports
//   clk_12m      in   system clock, 12 MHz
//   reset        in   synchronous, active-high
//   delta_valid  in   one-cycle strobe qualifying delta / delta_load
//   delta        in   signed step count, positive = paddle right
//   delta_load   in   0: add delta to accumulator, 1: overwrite accumulator
//   use_ext      in   1: enc follows the external encoder, 0: internal generator
//   ext_a/ext_b  in   raw encoder phases, asynchronous to clk_12m
//   enc          out  registered quadrature to the core
//   pending      out  accumulator value (signed steps still to emit)
//   busy         out  pending != 0
module spinner_quad_gen #(
    parameter int STEP_DIV = 3000,
    parameter int ACC_W    = 12,
    parameter int DELTA_W  = 12
) (
    input  logic               clk_12m,
    input  logic               reset,
    input  logic               delta_valid,
    input  logic [DELTA_W-1:0] delta,
    input  logic               delta_load,
    input  logic               use_ext,
    input  logic               ext_a,
    input  logic               ext_b,
    output logic [1:0]         enc,
    output logic [ACC_W-1:0]   pending,
    output logic               busy
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    // Two guard bits so pending - step + delta cannot overflow before clamping.
    localparam int WIDE = ACC_W + 2;
    localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [WIDE-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {
        Q_00 = 2'b00,
        Q_01 = 2'b01,
        Q_10 = 2'b10,
        Q_11 = 2'b11
    } quad_t;

    // Positive (paddle right) sequence: 11 -> 01 -> 00 -> 10 -> 11
    function automatic quad_t quad_fwd(input quad_t s);
        quad_t r;
        case (s)
            Q_11:    r = Q_01;
            Q_01:    r = Q_00;
            Q_00:    r = Q_10;
            default: r = Q_11;
        endcase
        return r;
    endfunction

    // Negative sequence: 11 -> 10 -> 00 -> 01 -> 11
    function automatic quad_t quad_rev(input quad_t s);
        quad_t r;
        case (s)
            Q_11:    r = Q_10;
            Q_10:    r = Q_00;
            Q_00:    r = Q_01;
            default: r = Q_11;
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] pending_q, pending_d;
    quad_t            int_state_q, int_state_d;
    quad_t            ext_state_q, ext_state_d;
    quad_t            enc_q, enc_d;
    logic             a_meta_q, a_meta_d, a_sync_q, a_sync_d, a_prev_q, a_prev_d;
    logic             b_meta_q, b_meta_d, b_sync_q, b_sync_d;

    logic                   tick;
    logic signed [WIDE-1:0] step_w;
    logic signed [WIDE-1:0] pend_ext;
    logic signed [WIDE-1:0] delta_ext;
    logic signed [WIDE-1:0] sum;
    logic signed [WIDE-1:0] sat;

    always_comb begin
        // Free-running rate divider
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        // Internal generator: direction taken from the pending value before any update
        int_state_d = int_state_q;
        step_w      = '0;
        if (tick) begin
            if (!pending_q[ACC_W-1] && (pending_q != '0)) begin
                int_state_d = quad_fwd(int_state_q);
                step_w      = WIDE'(1);
            end else if (pending_q[ACC_W-1]) begin
                int_state_d = quad_rev(int_state_q);
                step_w      = '1;
            end
        end

        // Accumulator; a load discards the tick adjustment of the same cycle
        pend_ext  = WIDE'(signed'(pending_q));
        delta_ext = WIDE'(signed'(delta));
        if (delta_valid && delta_load) begin
            sum = delta_ext;
        end else if (delta_valid) begin
            sum = pend_ext - step_w + delta_ext;
        end else begin
            sum = pend_ext - step_w;
        end
        // Symmetric clamp: the most negative code is never produced
        if (sum > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = sum;
        end
        pending_d = sat[ACC_W-1:0];

        // External encoder: two-stage synchronisers, step on either edge of A only
        a_meta_d    = ext_a;
        a_sync_d    = a_meta_q;
        a_prev_d    = a_sync_q;
        b_meta_d    = ext_b;
        b_sync_d    = b_meta_q;
        ext_state_d = ext_state_q;
        if (a_sync_q != a_prev_q) begin
            ext_state_d = (a_sync_q ^ b_sync_q) ? quad_rev(ext_state_q) : quad_fwd(ext_state_q);
        end

        enc_d = use_ext ? ext_state_q : int_state_q;
    end

    always_ff @(posedge clk_12m) begin
        if (reset) begin
            cnt_q       <= '0;
            pending_q   <= '0;
            int_state_q <= Q_11;
            ext_state_q <= Q_11;
            enc_q       <= Q_11;
            a_meta_q    <= 1'b0;
            a_sync_q    <= 1'b0;
            a_prev_q    <= 1'b0;
            b_meta_q    <= 1'b0;
            b_sync_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            int_state_q <= int_state_d;
            ext_state_q <= ext_state_d;
            enc_q       <= enc_d;
            a_meta_q    <= a_meta_d;
            a_sync_q    <= a_sync_d;
            a_prev_q    <= a_prev_d;
            b_meta_q    <= b_meta_d;
            b_sync_q    <= b_sync_d;
        end
    end

    assign enc     = enc_q;
    assign pending = pending_q;
    assign busy    = (pending_q != '0);

endmodule
